// File: rtl/mmio_hub_pkg.sv
// Shared constants for the MMIO hub: region codes and word-index constants.
package mmio_pkg;

  typedef enum logic [1:0] {
    REG_PARAM = 2'b00,
    REG_DATA  = 2'b01,
    REG_NONE  = 2'b10,
    REG_KBD   = 2'b11
  } region_e;

  localparam logic [3:0] STATUS_IDX = 4'd15;
  localparam logic [3:0] KBD_POP    = 4'd0;
  localparam logic [3:0] KBD_PEEK   = 4'd1;

endpackage

// File: rtl/mmio_hub_if.sv
// CPU data-port bus: strobes, address and data in both directions.
interface mmio_if;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (output mem_we, output mem_re, output mem_addr, output mem_wdata,
                  input  mem_rdata);
  modport slave  (input  mem_we, input  mem_re, input  mem_addr, input  mem_wdata,
                  output mem_rdata);
endinterface

// File: rtl/mmio_hub_kb_fifo.sv
// Keyboard code FIFO; head is read combinationally from the register array.
// Pushes while full and pops while empty are silently ignored.
module kb_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          wr, rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign head  = mem[rp];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_hub.sv
// MMIO hub: region decode, parameter bank, keyboard FIFO front-end and
// one-cycle registered read data.
module mmio_hub
  import mmio_pkg::*;
#(
  parameter int KB_DEPTH = 8,
  parameter int KB_W     = 16,
  parameter int NPARAM   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mmio_if.slave                 bus,
  output logic                  dm_we,
  output logic [12:0]           dm_addr,
  output logic [31:0]           dm_wdata,
  input  logic [31:0]           dm_rdata,
  input  logic                  kb_valid,
  input  logic [KB_W-1:0]       kb_code,
  output logic [15:0]           kb_char,
  output logic [32*NPARAM-1:0]  params
);

  localparam int AW = $clog2(KB_DEPTH);

  region_e     region;
  logic [3:0]  idx;
  logic [31:0] param_q [NPARAM];
  logic        overflow;
  logic        kb_pop, status_rd;
  logic [KB_W-1:0] kb_head;
  logic        kb_full, kb_empty;
  logic [AW:0] kb_count;
  logic [31:0] rd_val, rd_hold;
  logic        rd_pend, rd_is_data;

  assign region    = region_e'(bus.mem_addr[14:13]);
  assign idx       = bus.mem_addr[5:2];
  assign dm_we     = bus.mem_we && (region == REG_DATA);
  assign dm_addr   = bus.mem_addr[12:0];
  assign dm_wdata  = bus.mem_wdata;
  assign kb_pop    = bus.mem_re && (region == REG_KBD) && (idx == KBD_POP) && !kb_empty;
  assign status_rd = bus.mem_re && (region == REG_PARAM) && (idx == STATUS_IDX);

  kb_fifo #(.DEPTH(KB_DEPTH), .W(KB_W)) u_kb_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (kb_valid),
    .din   (kb_code),
    .pop   (kb_pop),
    .head  (kb_head),
    .full  (kb_full),
    .empty (kb_empty),
    .count (kb_count)
  );

  // Parameter register bank; index 15 is always STATUS and never writable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NPARAM; i++) param_q[i] <= '0;
    end else if (bus.mem_we && (region == REG_PARAM) && (idx != STATUS_IDX)) begin
      for (int unsigned i = 0; i < NPARAM; i++)
        if (idx == 4'(i)) param_q[i] <= bus.mem_wdata;
    end
  end

  // Sticky overflow: a drop in the same cycle as a STATUS read wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else        overflow <= (kb_valid && kb_full) || (overflow && !status_rd);
  end

  // Last popped keyboard code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      kb_char <= '0;
    else if (kb_pop) kb_char <= 16'(kb_head);
  end

  // Read value for non-RAM regions, taken from pre-edge state.
  always_comb begin
    rd_val = '0;
    case (region)
      REG_PARAM: begin
        if (idx == STATUS_IDX)
          rd_val = {16'h0, overflow, 7'h0, 8'(kb_count)};
        else
          for (int unsigned i = 0; i < NPARAM; i++)
            if (idx == 4'(i)) rd_val = param_q[i];
      end
      REG_KBD: begin
        if (((idx == KBD_POP) || (idx == KBD_PEEK)) && !kb_empty)
          rd_val = {1'b1, 15'h0, 16'(kb_head)};
      end
      default: rd_val = '0;
    endcase
  end

  // Two-stage read: capture decode/value at the strobe edge, present on the
  // next edge so synchronous RAM data lines up with the other regions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend       <= 1'b0;
      rd_is_data    <= 1'b0;
      rd_hold       <= '0;
      bus.mem_rdata <= '0;
    end else begin
      rd_pend <= bus.mem_re;
      if (bus.mem_re) begin
        rd_is_data <= (region == REG_DATA);
        rd_hold    <= rd_val;
      end
      if (rd_pend) bus.mem_rdata <= rd_is_data ? dm_rdata : rd_hold;
    end
  end

  // Flatten the parameter bank onto the output bus.
  always_comb begin
    params = '0;
    for (int unsigned i = 0; i < NPARAM; i++) params[32*i +: 32] = param_q[i];
  end

endmodule

// File: tb/tb_mmio_hub.sv
// Randomised scoreboard bench for mmio_hub with a queue-based reference model.
module tb_mmio_hub;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         dm_we;
  logic [12:0]  dm_addr;
  logic [31:0]  dm_wdata;
  logic [31:0]  dm_rdata = '0;
  logic         kb_valid = 1'b0;
  logic [15:0]  kb_code = '0;
  logic [15:0]  kb_char;
  logic [127:0] params;

  mmio_if bus ();

  mmio_hub #(.KB_DEPTH(8), .KB_W(16), .NPARAM(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .kb_valid (kb_valid),
    .kb_code  (kb_code),
    .kb_char  (kb_char),
    .params   (params)
  );

  always #5 clk = ~clk;

  // Synchronous data RAM environment.
  logic [31:0] ram [8192];
  initial for (int i = 0; i < 8192; i++) ram[i] = '0;
  always @(posedge clk) begin
    dm_rdata <= ram[dm_addr];
    if (dm_we) ram[dm_addr] <= dm_wdata;
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] rparam [4];
  logic [15:0] kbq [$];
  logic        rovf = 1'b0;
  logic [15:0] rkbchar = '0;
  logic [31:0] ref_mem [logic [12:0]];
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) rparam[i] = '0;
    kbq.delete();
    rovf = 1'b0;
    rkbchar = '0;
    exp_q.delete();
  endtask

  task automatic check_state();
    for (int i = 0; i < 4; i++) chk($sformatf("params[%0d]", i), params[32*i +: 32], rparam[i]);
    chk("kb_char", {16'h0, kb_char}, {16'h0, rkbchar});
  endtask

  // One bus cycle: drive at negedge, advance the model for the coming edge.
  task automatic step(input logic we, input logic re, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic kv, input logic [15:0] kc);
    int          sz0;
    logic [1:0]  r;
    logic [3:0]  ix;
    logic [31:0] ev;
    @(negedge clk);
    bus.mem_we = we; bus.mem_re = re; bus.mem_addr = addr; bus.mem_wdata = wdata;
    kb_valid = kv; kb_code = kc;
    sz0 = kbq.size();
    r = addr[14:13];
    ix = addr[5:2];
    if (re) begin
      ev = '0;
      case (r)
        2'd0: if (ix == 4'd15) ev = {16'h0, rovf, 7'h0, 8'(sz0)};
              else if (ix < 4'd4) ev = rparam[ix[1:0]];
        2'd1: if (ref_mem.exists(addr[12:0])) ev = ref_mem[addr[12:0]];
        2'd3: if ((ix == 4'd0 || ix == 4'd1) && sz0 > 0) begin
                ev = {16'h8000, kbq[0]};
                if (ix == 4'd0) begin
                  rkbchar = kbq[0];
                  void'(kbq.pop_front());
                end
              end
        default: ev = '0;
      endcase
      exp_q.push_back(ev);
      if (r == 2'd0 && ix == 4'd15) rovf = 1'b0;
    end
    if (we) begin
      if (r == 2'd0 && ix < 4'd4) rparam[ix[1:0]] = wdata;
      if (r == 2'd1) ref_mem[addr[12:0]] = wdata;
    end
    if (kv) begin
      if (sz0 == 8) rovf = 1'b1;
      else kbq.push_back(kc);
    end
    #1;
    chk("dm_we", {31'h0, dm_we}, {31'h0, we && (r == 2'd1)});
    if (we && r == 2'd1) begin
      chk("dm_addr", {19'h0, dm_addr}, {19'h0, addr[12:0]});
      chk("dm_wdata", dm_wdata, wdata);
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 16'h0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b0, 1'b1, a, 32'h0, 1'b0, 16'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d, 1'b0, 16'h0);
  endtask

  task automatic push(input logic [15:0] c);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, c);
  endtask

  task automatic reset_now();
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_we = 1'b0; bus.mem_re = 1'b0; kb_valid = 1'b0;
    model_reset();
    #1;
    chk("rst_mem_rdata", bus.mem_rdata, 32'h0);
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: a read sampled at one edge is compared after the following edge.
  initial begin : monitor
    logic pend;
    pend = 1'b0;
    forever begin
      @(posedge clk);
      if (pend && rst_n) begin
        #1;
        if (exp_q.size() == 0) chk("rdata_unexpected", bus.mem_rdata, 32'hxxxx_xxxx);
        else chk("mem_rdata", bus.mem_rdata, exp_q.pop_front());
      end
      pend = rst_n && bus.mem_re;
    end
  end

  initial begin : stim
    logic [31:0] hi, a, d;
    logic [1:0]  r;
    logic [3:0]  ix;
    logic [6:0]  lo;
    bus.mem_we = 1'b0; bus.mem_re = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    model_reset();
    #2;
    chk("por_mem_rdata", bus.mem_rdata, 32'h0);
    check_state();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Reset state reads
    rd(32'h0000_0000); rd(32'h0000_0004); rd(32'h0000_003C);
    // Param write / read-back / out-of-range index
    wr(32'h0000_0004, 32'h1234_5678);
    rd(32'h0000_0004);
    wr(32'h0000_0014, 32'hAAAA_5555);
    rd(32'h0000_0014);
    // Data RAM
    wr(32'h0000_2010, 32'hDEAD_BEEF);
    rd(32'h0000_2010);
    // Keyboard ordering and empty pop
    push(16'h001C); push(16'h00F0); push(16'h001C);
    rd(32'h0000_6000); rd(32'h0000_6000); rd(32'h0000_6000); rd(32'h0000_6000);
    // Overflow: nine pushes into eight entries
    for (int i = 0; i < 9; i++) push(16'(16'h0100 + i));
    rd(32'h0000_003C); rd(32'h0000_003C);
    for (int i = 0; i < 9; i++) rd(32'h0000_6000);
    // Single entry, simultaneous push and pop
    push(16'h0055);
    step(1'b0, 1'b1, 32'h0000_6000, 32'h0, 1'b1, 16'h0066);
    rd(32'h0000_003C);
    push(16'h0077);
    rd(32'h0000_6004);
    idle();
    // Mid-operation reset flushes the FIFO
    reset_now();
    rd(32'h0000_6000); rd(32'h0000_003C);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      hi = $urandom();
      r  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 6))
        0: ix = 4'd0;
        1: ix = 4'd1;
        2: ix = 4'd2;
        3: ix = 4'd3;
        4: ix = 4'd5;
        5: ix = 4'd15;
        default: ix = 4'($urandom_range(0, 15));
      endcase
      lo = 7'($urandom_range(0, 3));
      a  = {hi[31:15], r, lo, ix, 2'b00};
      d  = $urandom();
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 5, a, d,
           $urandom_range(0, 9) < 4, 16'($urandom()));
      if (n == 300) begin
        idle();
        reset_now();
      end
    end

    idle(); idle(); idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation exceeded its time budget");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_hub.md
# mmio_hub

Parametrised memory-mapped I/O hub between the soft-CPU data port and its peripherals: data RAM, a buffered PS/2 keyboard channel and a bank of fractal-core parameter registers. It decodes address bits [14:13] into four regions, returns registered read data one cycle after a read strobe, and queues keyboard codes in a FIFO so keystrokes between CPU polls are not lost.

## Interface
- `KB_DEPTH`, 8: keyboard FIFO entries; power of two, at least 2.
- `KB_W`, 16: keyboard code width; at most 16.
- `NPARAM`, 4: number of 32-bit parameter registers; 1 to 16. Index 0 is pan X, 1 is pan Y.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous reset, active low.
- `mem_we`  in  1  CPU write strobe.
- `mem_re`  in  1  CPU read strobe.
- `mem_addr`  in  32  CPU byte address.
- `mem_wdata`  in  32  CPU write data.
- `mem_rdata`  out  32  registered read data.
- `dm_we`  out  1  data RAM write enable.
- `dm_addr`  out  13  data RAM address; equals `mem_addr[12:0]`.
- `dm_wdata`  out  32  data RAM write data; equals `mem_wdata`.
- `dm_rdata`  in  32  data RAM read data; synchronous RAM, valid one cycle after address.
- `kb_valid`  in  1  one-cycle pulse from the keyboard decoder.
- `kb_code`  in  KB_W  code qualified by `kb_valid`.
- `kb_char`  out  16  last code popped by the CPU, zero-extended.
- `params`  out  32*NPARAM  flattened parameter registers; register i at bits [32*i +: 32].

## Operation
- Region is `mem_addr[14:13]`: 00 PARAM, 01 DATA, 10 unmapped, 11 KBD. Word index is `mem_addr[5:2]`.
- DATA: `dm_we = mem_we & (region==01)`. Reads return `dm_rdata`.
- PARAM: a write to index i < NPARAM loads register i. Index 15 is STATUS (read-only). Any other index at or above NPARAM reads 0 and ignores writes.
- STATUS read returns {16'b0, overflow, 7'b0, count[7:0]}. It clears `overflow` in the same cycle, unless an overflow occurs in that same cycle, in which case `overflow` stays set.
- KBD index 0 read (pop):
  - FIFO not empty: returns {1'b1, 15'b0, zero-extended head}, removes the head and loads `kb_char` with it.
  - FIFO empty: returns 0 and changes no state.
- KBD index 1 read (peek): returns {1'b1, 15'b0, head} without popping, or 0 if empty.
- Writes to KBD are ignored. Writes to unmapped space are ignored. Unmapped reads return 0.
- Push: `kb_valid` writes `kb_code` at the tail.
  - FIFO full: the code is dropped and `overflow` is set (sticky).
  - Push and pop in the same cycle on a non-empty FIFO: both happen and `count` is unchanged.
  - Push and pop in the same cycle on an empty FIFO: the pop returns 0; the push lands.
  - Pop in the same cycle a full-drop occurs: the dropped code is not retried.
- Pointers are log2(KB_DEPTH) bits wide and wrap modulo KB_DEPTH.
- `count` is log2(KB_DEPTH)+1 bits, zero-extended to 8 in STATUS.
- When `mem_we` and `mem_re` are both high, the write takes priority and the read still returns pre-write data.

## Timing
- Reset, asynchronous assertion, values:
  - `mem_rdata` = 0
  - `kb_char` = 0
  - all `params` = 0
  - FIFO empty, `count` = 0
  - `overflow` = 0
- Reset mid-operation flushes queued codes.
- Read latency is 1 cycle. The region, index and pop decision are captured at the `mem_re` edge. `mem_rdata` updates at the next edge and then holds until the next `mem_re`.
- Pop side effects (pointer, `count`, `kb_char`) take effect at the edge where `mem_re` is sampled.
- Param writes are visible on `params` the cycle after `mem_we`.
- `dm_we`, `dm_addr` and `dm_wdata` are combinational, with no added latency.
- A code pushed at edge N can be popped by a read sampled at edge N+1 or later.

## Structure
- Package `mmio_pkg`: region codes (REG_PARAM, REG_DATA, REG_NONE, REG_KBD), the STATUS index constant (15), and the KBD index constants (POP=0, PEEK=1).
- Sub-module `kb_fifo`, parameterised by depth and width. Ports: push/pop, head, full/empty, count. It reads from a register array, so the head is available combinationally.
- Hub top: decode, param register bank, overflow flag, read-data register.

## Test plan
- Reset, then read PARAM idx 0, 1 and STATUS -> all read 0; `params` == 0.
- Write 0x12345678 to 0x0000_0004 (idx 1) -> `params[63:32]` == 0x12345678 on the next cycle; read-back matches. Write to idx 5 with NPARAM=4 -> ignored, reads 0.
- Write 0xDEADBEEF at 0x2010 -> `dm_we`=1 with `dm_addr`=0x010. Read 0x2010 with `dm_rdata`=0xDEADBEEF -> `mem_rdata` = 0xDEADBEEF one cycle later.
- Push 0x001C, 0x00F0, 0x001C, then pop three times at 0x6000 -> 0x8000001C, 0x800000F0, 0x8000001C in order; `kb_char` == 0x001C at the end; a fourth pop -> 0.
- Push 9 codes with KB_DEPTH=8 -> STATUS = 0x0000_8008. Read again -> 0x0000_0008 (overflow cleared). The 9th code is never popped.
- FIFO holding 1 entry, simultaneous push and pop -> count stays 1 and the old head is returned. Assert `rst_n` mid-sequence -> FIFO empty and `mem_rdata` = 0 immediately.
